sha0_digest_serializer: RTL and testbench
=========================================

// Module: sha0_digest_serializer
// PURPOSE
//   Downstream consumer of sha0_core. Captures the 160-bit digest (digest0..digest4) on the
//   single-cycle digest_valid pulse. Streams it out big-endian over a valid/ready byte interface,
//   as raw bytes or as lowercase ASCII hex with an optional trailing newline.
//   Feeds the UART/log/host byte path so the hash result leaves the chip.
// PARAMETERS
//   HEX_ASCII  1  1: 40 lowercase ASCII hex chars; 0: 20 raw digest bytes
//   APPEND_NL  1  1: append one 0x0A byte after the digest bytes; 0: none
// PORTS
//   clk           in   1   single clock, rising edge
//   rst           in   1   asynchronous reset, active-high
//   digest_valid  in   1   1-cycle pulse from sha0_core; digest0..4 valid in that cycle
//   digest0       in   32  H0 (most significant word, emitted first)
//   digest1       in   32  H1
//   digest2       in   32  H2
//   digest3       in   32  H3
//   digest4       in   32  H4 (emitted last)
//   out_valid     out  1   out_data holds a byte
//   out_data      out  8   current output byte
//   out_last      out  1   qualifies the final byte of the record (with out_valid)
//   out_ready     in   1   consumer accepts the byte when out_valid && out_ready
//   busy          out  1   high from the cycle after capture until the final handshake
//   done          out  1   1-cycle pulse, the cycle after the final handshake
//   drop_err      out  1   sticky; set when a digest_valid is dropped
// BEHAVIOUR
// - Reset (async, rst=1): state S_IDLE, byte index 0, digest register 0.
//   All outputs 0: out_valid, out_data, out_last, busy, done, drop_err.
// - Record length N:
//   - N = 20 raw / 40 hex, plus 1 if APPEND_NL=1.
//   - Byte index idx is 6 bits, range 0..N-1.
// - FSM:
//   - S_IDLE: digest_valid=1 -> latch {digest0..digest4} into dreg[159:0], idx<=0 -> S_EMIT.
//   - S_EMIT: out_valid=1. On handshake:
//     - if idx == last digest byte: go to S_NL when APPEND_NL, else S_IDLE and pulse done.
//     - otherwise idx<=idx+1.
//   - S_NL: out_valid=1, out_data=8'h0A, out_last=1. On handshake -> S_IDLE, done pulses next cycle.
// - Latency: out_valid rises the cycle after digest_valid.
//   With out_ready held 1, one byte per cycle; the record takes N cycles.
// - Byte mapping:
//   - raw: out_data = dreg[159-8*idx -: 8].
//   - hex: nibble n = dreg[159-4*idx -: 4];
//     out_data = (n<10) ? 8'h30+n : 8'h61+n-10.
// - out_last: 1 only on the record's final byte (the last digest byte when APPEND_NL=0, else the 0x0A).
// - Stability: while out_valid && !out_ready, out_data, out_last and idx hold.
//   out_valid never deasserts without a handshake.
// - busy: 1 in S_EMIT/S_NL, 0 in S_IDLE.
// - done: registered; high exactly one cycle after the handshake that returns the FSM to S_IDLE.
// - Overlap: digest_valid while state != S_IDLE (including the final-handshake cycle) is ignored.
//   dreg is unchanged and drop_err is set, cleared only by rst.
// - digest_valid in the S_IDLE cycle that follows a completed record is accepted normally.
// - Reset mid-record: the stream aborts immediately; out_valid drops asynchronously and no done pulse follows.
// - No arithmetic beyond the idx increment and the nibble add; all values are unsigned.
// TESTING
// - T1 hex+NL: digest 0164b8a9 14cd2a5e 74c4f7ff 082c4d97 f1edf880 (SHA-0 "abc"), out_ready=1.
//   -> 41 bytes 0x30,0x31,0x36,0x34,0x62,0x38,...,0x38,0x30,0x0A.
//   -> out_last only on 0x0A; done pulses 1 cycle later.
// - T2 raw, APPEND_NL=0, same digest:
//   -> 20 bytes 0x01,0x64,0xB8,0xA9,...,0xF8,0x80; out_last on 0x80; busy high for 20 cycles.
// - T3 backpressure: hex mode, out_ready toggles 1,0,0,1 pseudo-randomly.
//   -> byte sequence identical to T1; out_data/out_last stable on every stalled cycle.
// - T4 overlap: a second digest_valid (all-FF digest) at byte 10.
//   -> first record completes unchanged and drop_err=1; after idle, a third digest_valid of all-FF -> "ffff...f".
// - T5 reset: assert rst at byte 5 of a record.
//   -> out_valid=0, busy=0, done=0, drop_err=0 immediately.
//   -> after release, a new digest streams from idx 0.
// - T6 back-to-back: digest_valid one cycle after done.
//   -> captured, no drop_err, out_valid high the next cycle.

Source files
------------

// File: rtl/sha0_digest_serializer.sv
// Captures a 160-bit SHA-0 digest and streams it MSB-first over a valid/ready byte port,
// either as raw bytes or as lowercase ASCII hex, optionally terminated by a newline.
module sha0_digest_serializer #(
    parameter bit HEX_ASCII = 1'b1,
    parameter bit APPEND_NL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        digest_valid,
    input  logic [31:0] digest0,
    input  logic [31:0] digest1,
    input  logic [31:0] digest2,
    input  logic [31:0] digest3,
    input  logic [31:0] digest4,
    output logic        out_valid,
    output logic [7:0]  out_data,
    output logic        out_last,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        drop_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EMIT = 2'd1;
    localparam logic [1:0] S_NL   = 2'd2;

    localparam logic [5:0] LAST_IDX = HEX_ASCII ? 6'd39 : 6'd19;

    logic [1:0]   state_q, state_d;
    logic [5:0]   idx_q, idx_d;
    logic [159:0] dreg_q, dreg_d;
    logic         done_q, done_d;
    logic         drop_q, drop_d;

    logic         hs;
    logic         at_last_dig;
    logic [7:0]   nib_pos;
    logic [7:0]   byte_pos;
    logic [3:0]   nib;
    logic [7:0]   raw_byte;
    logic [7:0]   hex_char;

    assign hs          = out_valid && out_ready;
    assign at_last_dig = (idx_q == LAST_IDX);

    // Bit positions of the current nibble/byte, counted down from the MSB of H0.
    assign nib_pos  = 8'd159 - {idx_q, 2'b00};
    assign byte_pos = 8'd159 - {idx_q[4:0], 3'b000};
    assign nib      = dreg_q[nib_pos -: 4];
    assign raw_byte = dreg_q[byte_pos -: 8];
    assign hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dreg_d  = dreg_q;
        done_d  = 1'b0;
        drop_d  = drop_q;
        case (state_q)
            S_IDLE: begin
                if (digest_valid) begin
                    dreg_d  = {digest0, digest1, digest2, digest3, digest4};
                    idx_d   = 6'd0;
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (hs) begin
                    if (at_last_dig) begin
                        if (APPEND_NL) begin
                            state_d = S_NL;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            S_NL: begin
                if (hs) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A new digest arriving while a record is in flight is lost; flag it.
        if (digest_valid && (state_q != S_IDLE)) begin
            drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= 6'd0;
            dreg_q  <= 160'd0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dreg_q  <= dreg_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    // Outputs decode the registered state only, so reset drops them at once.
    always_comb begin
        out_valid = (state_q == S_EMIT) || (state_q == S_NL);
        out_last  = (state_q == S_NL) ||
                    ((state_q == S_EMIT) && at_last_dig && !APPEND_NL);
        case (state_q)
            S_EMIT:  out_data = HEX_ASCII ? hex_char : raw_byte;
            S_NL:    out_data = 8'h0A;
            default: out_data = 8'h00;
        endcase
    end

    assign busy     = out_valid;
    assign done     = done_q;
    assign drop_err = drop_q;

endmodule

// File: tb/tb_sha0_digest_serializer.sv
// Directed bench: a hex+newline instance and a raw/no-newline instance fed from one stimulus thread.
module tb_sha0_digest_serializer;

    localparam logic [159:0] ABC  = 160'h0164b8a9_14cd2a5e_74c4f7ff_082c4d97_f1edf880;
    localparam logic [159:0] ALLF = {160{1'b1}};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] d0, d1, d2, d3, d4;
    logic        dv_h = 1'b0, dv_r = 1'b0, rdy_h = 1'b0, rdy_r = 1'b0;
    logic        h_ov, h_last, h_busy, h_done, h_drop;
    logic        r_ov, r_last, r_busy, r_done, r_drop;
    logic [7:0]  h_data, r_data;

    bit          cur;
    logic        ov, lst, bsy, dn, drp;
    logic [7:0]  dat;
    logic [7:0]  sbq[$];
    int          checks = 0;
    int          failures = 0;
    int          bc;

    always #5 clk = ~clk;

    sha0_digest_serializer #(.HEX_ASCII(1'b1), .APPEND_NL(1'b1)) dut_hex (
        .clk(clk), .rst(rst), .digest_valid(dv_h),
        .digest0(d0), .digest1(d1), .digest2(d2), .digest3(d3), .digest4(d4),
        .out_valid(h_ov), .out_data(h_data), .out_last(h_last), .out_ready(rdy_h),
        .busy(h_busy), .done(h_done), .drop_err(h_drop)
    );

    sha0_digest_serializer #(.HEX_ASCII(1'b0), .APPEND_NL(1'b0)) dut_raw (
        .clk(clk), .rst(rst), .digest_valid(dv_r),
        .digest0(d0), .digest1(d1), .digest2(d2), .digest3(d3), .digest4(d4),
        .out_valid(r_ov), .out_data(r_data), .out_last(r_last), .out_ready(rdy_r),
        .busy(r_busy), .done(r_done), .drop_err(r_drop)
    );

    assign ov  = cur ? r_ov   : h_ov;
    assign lst = cur ? r_last : h_last;
    assign bsy = cur ? r_busy : h_busy;
    assign dn  = cur ? r_done : h_done;
    assign drp = cur ? r_drop : h_drop;
    assign dat = cur ? r_data : h_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected byte stream, built with a character lookup rather than arithmetic.
    task automatic push(input logic [159:0] d, input bit hex, input bit nl);
        string      hx = "0123456789abcdef";
        logic [3:0] n;
        if (hex) begin
            for (int i = 0; i < 40; i++) begin
                n = d[159-4*i -: 4];
                sbq.push_back(hx[n]);
            end
        end else begin
            for (int i = 0; i < 20; i++) sbq.push_back(d[159-8*i -: 8]);
        end
        if (nl) sbq.push_back(8'h0A);
    endtask

    task automatic start(input bit sel, input logic [159:0] d);
        cur = sel;
        {d0, d1, d2, d3, d4} = d;
        if (sel) dv_r = 1'b1; else dv_h = 1'b1;
        push(d, !sel, !sel);
        tick();
        dv_h = 1'b0;
        dv_r = 1'b0;
        chk("latency_valid", 32'(ov), 32'd1);
    endtask

    // mode 0: ready held high; mode 1: random ready. inj_at/abort_at < 0 disable.
    task automatic drain(input int mode, input int inj_at, input int abort_at, output int busy_cnt);
        int n = 0;
        int cyc = 0;
        bit rdy;
        bit inj = 1'b0;
        busy_cnt = 0;
        while (sbq.size() > 0 && cyc < 400) begin
            if (n == abort_at) begin
                #1 rst = 1'b1;
                #1;
                chk("rst_valid", 32'(ov), 32'd0);
                chk("rst_busy",  32'(bsy), 32'd0);
                chk("rst_done",  32'(dn), 32'd0);
                chk("rst_drop",  32'(drp), 32'd0);
                chk("rst_data",  32'(dat), 32'd0);
                sbq.delete();
                rdy_h = 1'b0;
                rdy_r = 1'b0;
                return;
            end
            rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (cur) rdy_r = rdy; else rdy_h = rdy;
            if (n == inj_at && !inj) begin
                {d0, d1, d2, d3, d4} = ALLF;
                dv_h = 1'b1;
                inj  = 1'b1;
            end else begin
                dv_h = 1'b0;
            end
            chk("valid", 32'(ov), 32'd1);
            chk("data",  32'(dat), 32'(sbq[0]));
            chk("last",  32'(lst), 32'(sbq.size() == 1));
            busy_cnt += int'(bsy);
            if (rdy) begin
                void'(sbq.pop_front());
                n++;
            end
            tick();
            cyc++;
        end
        dv_h  = 1'b0;
        rdy_h = 1'b0;
        rdy_r = 1'b0;
        chk("timeout_left", 32'(sbq.size()), 32'd0);
        chk("end_valid",  32'(ov), 32'd0);
        chk("end_busy",   32'(bsy), 32'd0);
        chk("done_pulse", 32'(dn), 32'd1);
    endtask

    initial begin
        cur = 1'b0;
        {d0, d1, d2, d3, d4} = '0;
        #12;
        chk("rst_h_valid", 32'(h_ov), 32'd0);
        chk("rst_h_data",  32'(h_data), 32'd0);
        chk("rst_h_last",  32'(h_last), 32'd0);
        chk("rst_h_busy",  32'(h_busy), 32'd0);
        chk("rst_h_done",  32'(h_done), 32'd0);
        chk("rst_h_drop",  32'(h_drop), 32'd0);
        chk("rst_r_valid", 32'(r_ov), 32'd0);
        chk("rst_r_data",  32'(r_data), 32'd0);
        @(negedge clk) rst = 1'b0;
        tick();

        // T1: hex + newline, ready always high
        start(1'b0, ABC);
        drain(0, -1, -1, bc);
        chk("t1_busy_cycles", 32'(bc), 32'd41);
        tick();
        chk("t1_done_once", 32'(dn), 32'd0);

        // T2: raw, no newline
        start(1'b1, ABC);
        drain(0, -1, -1, bc);
        chk("t2_busy_cycles", 32'(bc), 32'd20);
        tick();
        chk("t2_done_once", 32'(dn), 32'd0);

        // T3: backpressure
        start(1'b0, ABC);
        drain(1, -1, -1, bc);
        chk("t3_drop", 32'(drp), 32'd0);
        tick();

        // T4: overlapping digest_valid at byte 10, then an accepted all-FF record
        start(1'b0, ABC);
        drain(0, 10, -1, bc);
        chk("t4_drop_set", 32'(drp), 32'd1);
        tick();
        start(1'b0, ALLF);
        drain(1, -1, -1, bc);
        chk("t4_drop_sticky", 32'(drp), 32'd1);
        tick();

        // T5: reset at byte 5, then a fresh record from idx 0
        start(1'b0, 160'h0123456789abcdef_fedcba9876543210_a5a5a5a5);
        drain(0, -1, 5, bc);
        @(negedge clk) rst = 1'b0;
        tick();
        chk("t5_idle_valid", 32'(ov), 32'd0);
        chk("t5_no_done",    32'(dn), 32'd0);
        start(1'b0, ABC);
        drain(0, -1, -1, bc);

        // T6: digest_valid in the done cycle is accepted
        start(1'b0, 160'hdeadbeef_00000000_9abcdef0_13579bdf_02468ace);
        chk("t6_no_drop", 32'(drp), 32'd0);
        chk("t6_busy",    32'(bsy), 32'd1);
        drain(1, -1, -1, bc);
        chk("t6_drop_end", 32'(drp), 32'd0);
        tick();
        chk("t6_done_once", 32'(dn), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
